// File: rtl/qerv_dbus_pkg.sv
// Shared FSM encoding and limits for the qerv data-bus SRAM responder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package qerv_dbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_HOLD   = 3'd4
  } dbus_state_t;

  localparam int WS_MAX = 15;

endpackage

// File: rtl/qerv_dbus_wscnt.sv
// Wait-state down-counter: loads a start value, decrements toward zero, flags zero.
// Latency: o_zero follows the registered count one cycle after load/decrement.
// Backpressure: none; the caller gates decrement and saturation holds it at zero.
module qerv_dbus_wscnt (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= 4'd0;
    end else if (i_load) begin
      cnt <= i_load_val;
    end else if (i_dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign o_zero = (cnt == 4'd0);

endmodule

// File: rtl/qerv_dbus_ram_resp.sv
// Wishbone-classic data-bus responder backed by a single-port byte-enable sync SRAM.
// Latency: request captured at edge 0, SRAM enabled after edge WAIT_STATES, ack/err+rdt after edge 2+WAIT_STATES.
// Backpressure: master holds cyc until ack/err; one HOLD cycle follows every response, cyc drop in WAIT aborts.
module qerv_dbus_ram_resp
  import qerv_dbus_pkg::*;
#(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_CHECK  = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_be,
  output logic          o_mem_we,
  output logic          o_mem_en,
  input  logic [31:0]   i_mem_rdata
);

  localparam int          WS      = (WAIT_STATES > WS_MAX) ? WS_MAX : WAIT_STATES;
  localparam logic [3:0]  WS_LOAD = (WS > 0) ? 4'(WS - 1) : 4'd0;
  localparam logic [30:0] DEPTH   = 31'(1) << AW;

  dbus_state_t   state;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_dat;
  logic [3:0]    req_sel;
  logic          req_we;
  logic          req_err;
  logic          adr_oor;
  logic          ws_load;
  logic          ws_dec;
  logic          ws_zero;
  logic          unused_adr;

  // Compare the full word address so bits above the SRAM depth cannot alias.
  assign adr_oor    = (ADDR_CHECK != 0) && ({1'b0, i_wb_adr[31:2]} >= DEPTH);
  assign unused_adr = ^i_wb_adr[1:0];

  assign ws_load = (state == ST_IDLE) && i_wb_cyc;
  assign ws_dec  = (state == ST_WAIT) && !ws_zero;

  qerv_dbus_wscnt u_wscnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (ws_load),
    .i_load_val (WS_LOAD),
    .i_dec      (ws_dec),
    .o_zero     (ws_zero)
  );

  assign o_mem_addr  = req_addr;
  assign o_mem_wdata = req_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      req_addr <= '0;
      req_dat  <= 32'h0;
      req_sel  <= 4'h0;
      req_we   <= 1'b0;
      req_err  <= 1'b0;
      o_mem_en <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_be <= 4'h0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_rdt <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_wb_cyc) begin
            req_addr <= i_wb_adr[AW+1:2];
            req_dat  <= i_wb_dat;
            req_sel  <= i_wb_sel;
            req_we   <= i_wb_we;
            req_err  <= adr_oor;
            if (WS == 0) begin
              state    <= ST_ACCESS;
              o_mem_en <= !adr_oor;
              o_mem_we <= i_wb_we && !adr_oor;
              o_mem_be <= adr_oor ? 4'h0 : i_wb_sel;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!i_wb_cyc) begin
            state <= ST_IDLE;
          end else if (ws_zero) begin
            state    <= ST_ACCESS;
            o_mem_en <= !req_err;
            o_mem_we <= req_we && !req_err;
            o_mem_be <= req_err ? 4'h0 : req_sel;
          end
        end
        ST_ACCESS: begin
          o_mem_en <= 1'b0;
          o_mem_we <= 1'b0;
          o_mem_be <= 4'h0;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          // SRAM read data is valid this cycle; it lands in rdt alongside ack.
          if (req_err) begin
            o_wb_err <= 1'b1;
            if (!req_we) o_wb_rdt <= 32'h0;
          end else begin
            o_wb_ack <= 1'b1;
            if (!req_we) o_wb_rdt <= i_mem_rdata;
          end
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          o_wb_ack <= 1'b0;
          o_wb_err <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qerv_dbus_ram_resp.sv
// Bench for qerv_dbus_ram_resp: two instances (0 and 3 wait states) each on a behavioural SRAM,
// checked against a transaction-level memory model and the documented response timing.
module tb_qerv_dbus_ram_resp;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]   wb_adr    [2];
  logic [31:0]   wb_dat    [2];
  logic [3:0]    wb_sel    [2];
  logic          wb_we     [2];
  logic          wb_cyc    [2];
  logic [31:0]   wb_rdt    [2];
  logic          wb_ack    [2];
  logic          wb_err    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [31:0]   mem_wdata [2];
  logic [3:0]    mem_be    [2];
  logic          mem_we    [2];
  logic          mem_en    [2];
  logic [31:0]   mem_rdata [2];

  logic [31:0] ram     [2][DEPTH];
  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] exp_rdt [2];
  logic [31:0] rd;
  int tests = 0;
  int fails = 0;

  qerv_dbus_ram_resp #(.AW(AW), .WAIT_STATES(0), .ADDR_CHECK(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_adr(wb_adr[0]), .i_wb_dat(wb_dat[0]), .i_wb_sel(wb_sel[0]), .i_wb_we(wb_we[0]), .i_wb_cyc(wb_cyc[0]),
    .o_wb_rdt(wb_rdt[0]), .o_wb_ack(wb_ack[0]), .o_wb_err(wb_err[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]), .o_mem_be(mem_be[0]), .o_mem_we(mem_we[0]),
    .o_mem_en(mem_en[0]), .i_mem_rdata(mem_rdata[0])
  );

  qerv_dbus_ram_resp #(.AW(AW), .WAIT_STATES(3), .ADDR_CHECK(1)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_adr(wb_adr[1]), .i_wb_dat(wb_dat[1]), .i_wb_sel(wb_sel[1]), .i_wb_we(wb_we[1]), .i_wb_cyc(wb_cyc[1]),
    .o_wb_rdt(wb_rdt[1]), .o_wb_ack(wb_ack[1]), .o_wb_err(wb_err[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]), .o_mem_be(mem_be[1]), .o_mem_we(mem_we[1]),
    .o_mem_en(mem_en[1]), .i_mem_rdata(mem_rdata[1])
  );

  // Single-port byte-enable sync SRAMs: read data appears the cycle after enable.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) begin
        if (mem_we[k]) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[k][b]) ram[k][mem_addr[k]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
        end else begin
          mem_rdata[k] <= ram[k][mem_addr[k]];
        end
      end
    end
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // One complete transfer; edge n is the n-th rising edge after cyc is raised (edge 0 captures).
  task automatic run_xfer(input int k, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, input int hold_extra, input string tag, output logic [31:0] got);
    int ws = ws_of(k);
    bit oor = (adr[31:2] >= 30'(DEPTH));
    int en_cnt = 0, en_at = -1, ack_cnt = 0, err_cnt = 0, resp_at = -1, bad = 0;
    logic [AW-1:0] en_addr = '0;
    logic [3:0]    en_be = 4'h0;
    logic          en_we = 1'b0;
    logic [31:0]   en_wdata = 32'h0;
    got = 32'h0;
    if (!we) exp_rdt[k] = oor ? 32'h0 : ref_mem[k][adr[AW+1:2]];
    else if (!oor)
      for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[k][adr[AW+1:2]][8*b +: 8] = dat[8*b +: 8];
    wb_adr[k] = adr; wb_dat[k] = dat; wb_sel[k] = sel; wb_we[k] = we; wb_cyc[k] = 1'b1;
    for (int n = 0; n <= ws + 4; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        wb_adr[k] = $urandom; wb_dat[k] = $urandom; wb_sel[k] = 4'($urandom); wb_we[k] = ~we;
      end
      if (mem_en[k]) begin
        en_cnt++; en_at = n; en_addr = mem_addr[k]; en_be = mem_be[k]; en_we = mem_we[k]; en_wdata = mem_wdata[k];
      end else if (mem_be[k] != 4'h0 || mem_we[k]) bad++;
      if (wb_ack[k]) begin ack_cnt++; resp_at = n; got = wb_rdt[k]; end
      if (wb_err[k]) begin err_cnt++; resp_at = n; got = wb_rdt[k]; end
      if (wb_ack[k] && wb_err[k]) bad++;
      if (n == ws + 2 + hold_extra) wb_cyc[k] = 1'b0;
    end
    tests++;
    if (en_cnt != (oor ? 0 : 1)) begin
      fails++; $display("FAIL %s en_count: got %0d want %0d", tag, en_cnt, oor ? 0 : 1);
    end
    if (!oor) begin
      tests++;
      if (en_at != ws) begin fails++; $display("FAIL %s en_cycle: got %0d want %0d", tag, en_at, ws); end
      tests++;
      if ({en_addr, en_be, en_we} !== {adr[AW+1:2], sel, we}) begin
        fails++; $display("FAIL %s mem_cmd: got addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                          tag, en_addr, en_be, en_we, adr[AW+1:2], sel, we);
      end
      if (we) begin
        tests++;
        if (en_wdata !== dat) begin fails++; $display("FAIL %s wdata: got %h want %h", tag, en_wdata, dat); end
      end
    end
    tests++;
    if (ack_cnt != (oor ? 0 : 1) || err_cnt != (oor ? 1 : 0)) begin
      fails++; $display("FAIL %s resp_kind: got ack=%0d err=%0d want ack=%0d err=%0d",
                        tag, ack_cnt, err_cnt, oor ? 0 : 1, oor ? 1 : 0);
    end
    tests++;
    if (resp_at != ws + 2) begin fails++; $display("FAIL %s resp_cycle: got %0d want %0d", tag, resp_at, ws + 2); end
    tests++;
    if (got !== exp_rdt[k]) begin fails++; $display("FAIL %s rdt: got %h want %h", tag, got, exp_rdt[k]); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL %s idle_strobes: got %0d want 0", tag, bad); end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      wb_adr[k] = 32'h0; wb_dat[k] = 32'h0; wb_sel[k] = 4'h0; wb_we[k] = 1'b0; wb_cyc[k] = 1'b0;
      exp_rdt[k] = 32'h0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({wb_rdt[k], wb_ack[k], wb_err[k], mem_en[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k]} !== '0) begin
        fails++; $display("FAIL reset_outputs[%0d]: got rdt=%h ack=%b err=%b en=%b we=%b be=%b addr=%h wdata=%h want all 0",
                          k, wb_rdt[k], wb_ack[k], wb_err[k], mem_en[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    logic [31:0] r;
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 16; w++) run_xfer(k, 32'(w) << 2, $urandom, 4'hF, 1'b1, 0, "preload", r);
  endtask

  task automatic test_load();
    logic [31:0] r;
    run_xfer(0, 32'h14, 32'hDEADBEEF, 4'hF, 1'b1, 0, "store_deadbeef", r);
    run_xfer(0, 32'h14, 32'h0, 4'hF, 1'b0, 0, "load_deadbeef", r);
    tests++;
    if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL load_literal: got %h want deadbeef", r); end
  endtask

  task automatic test_byte_store();
    logic [31:0] r;
    run_xfer(0, 32'h8, 32'h11223344, 4'hF, 1'b1, 0, "store_full", r);
    run_xfer(0, 32'h8, 32'h00AB0000, 4'b0100, 1'b1, 0, "store_byte2", r);
    run_xfer(0, 32'h8, 32'h0, 4'hF, 1'b0, 0, "reload_byte2", r);
    tests++;
    if (r !== 32'h11AB3344) begin fails++; $display("FAIL byte_merge: got %h want 11ab3344", r); end
    run_xfer(0, 32'hA, 32'hFFFFFFFF, 4'h0, 1'b1, 0, "store_sel0", r);
    run_xfer(0, 32'h8, 32'h0, 4'hF, 1'b0, 0, "reload_sel0", r);
    tests++;
    if (r !== 32'h11AB3344) begin fails++; $display("FAIL sel0_noop: got %h want 11ab3344", r); end
  endtask

  task automatic test_wait_states();
    logic [31:0] r;
    run_xfer(1, 32'h14, 32'h0, 4'hF, 1'b0, 0, "ws3_load", r);
    run_xfer(1, 32'h24, 32'hCAFEF00D, 4'b0011, 1'b1, 0, "ws3_store", r);
  endtask

  task automatic test_addr_check();
    logic [31:0] r;
    run_xfer(0, 32'h1000, 32'h0, 4'hF, 1'b0, 0, "oor_load", r);
    run_xfer(1, 32'hFFFFFFFC, 32'h12345678, 4'hF, 1'b1, 0, "oor_store", r);
    run_xfer(1, 32'h0, 32'h0, 4'hF, 1'b0, 0, "after_oor_store", r);
  endtask

  task automatic test_hold();
    logic [31:0] r;
    run_xfer(0, 32'h1C, 32'h0, 4'hF, 1'b0, 1, "hold_ws0", r);
    run_xfer(1, 32'h1C, 32'h0, 4'hF, 1'b0, 1, "hold_ws3", r);
  endtask

  task automatic test_back_to_back();
    int en_q[$];
    int ack_q[$];
    logic [31:0] rdt_q[$];
    logic [31:0] ea, eb;
    ea = ref_mem[0][3]; eb = ref_mem[0][7];
    wb_adr[0] = 32'hC; wb_we[0] = 1'b0; wb_sel[0] = 4'hF; wb_cyc[0] = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      @(posedge clk); #1;
      if (mem_en[0]) en_q.push_back(n);
      if (wb_ack[0]) begin ack_q.push_back(n); rdt_q.push_back(wb_rdt[0]); end
      if (n == 2) wb_adr[0] = 32'h1C;
      if (n == 6) wb_cyc[0] = 1'b0;
    end
    exp_rdt[0] = eb;
    tests++;
    if (en_q.size() != 2 || en_q[0] != 0 || en_q[1] != 4) begin
      fails++; $display("FAIL b2b_en_cycles: got %p want '{0, 4}", en_q);
    end
    tests++;
    if (ack_q.size() != 2 || ack_q[0] != 2 || ack_q[1] != 6) begin
      fails++; $display("FAIL b2b_ack_cycles: got %p want '{2, 6}", ack_q);
    end
    tests++;
    if (rdt_q.size() != 2 || rdt_q[0] !== ea || rdt_q[1] !== eb) begin
      fails++; $display("FAIL b2b_rdt: got %p want %h %h", rdt_q, ea, eb);
    end
  endtask

  task automatic test_abort();
    int en_cnt = 0, en_at = -1, ack_cnt = 0, ack_at = -1;
    logic en_we = 1'b0;
    logic [31:0] got = 32'h0;
    logic [31:0] want;
    want = ref_mem[1][4];
    wb_adr[1] = 32'h10; wb_dat[1] = 32'hFFFFFFFF; wb_sel[1] = 4'hF; wb_we[1] = 1'b1; wb_cyc[1] = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      @(posedge clk); #1;
      if (mem_en[1]) begin en_cnt++; en_at = n; en_we = mem_we[1]; end
      if (wb_ack[1] || wb_err[1]) begin ack_cnt++; ack_at = n; got = wb_rdt[1]; end
      if (n == 1) wb_cyc[1] = 1'b0;
      if (n == 2) begin wb_we[1] = 1'b0; wb_cyc[1] = 1'b1; end
      if (n == 8) wb_cyc[1] = 1'b0;
    end
    exp_rdt[1] = want;
    tests++;
    if (en_cnt != 1 || en_at != 6 || en_we !== 1'b0) begin
      fails++; $display("FAIL abort_mem_en: got count=%0d cycle=%0d we=%b want count=1 cycle=6 we=0", en_cnt, en_at, en_we);
    end
    tests++;
    if (ack_cnt != 1 || ack_at != 8) begin
      fails++; $display("FAIL abort_ack: got count=%0d cycle=%0d want count=1 cycle=8", ack_cnt, ack_at);
    end
    tests++;
    if (got !== want) begin fails++; $display("FAIL abort_rdt: got %h want %h", got, want); end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    logic [31:0] r;
    wb_adr[0] = 32'h14; wb_we[0] = 1'b0; wb_sel[0] = 4'hF; wb_cyc[0] = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (mem_en[0] !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_en: got %b want 1", mem_en[0]); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_en[0], mem_we[0], wb_ack[0], wb_err[0], wb_rdt[0]} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: got en=%b we=%b ack=%b err=%b rdt=%h want all 0",
                        mem_en[0], mem_we[0], wb_ack[0], wb_err[0], wb_rdt[0]);
    end
    wb_cyc[0] = 1'b0;
    exp_rdt[0] = 32'h0; exp_rdt[1] = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (wb_ack[0] || wb_err[0] || mem_en[0]) acks++;
    end
    tests++;
    if (acks != 0) begin fails++; $display("FAIL rst_mid_no_late_resp: got %0d want 0", acks); end
    run_xfer(0, 32'h14, 32'h0, 4'hF, 1'b0, 0, "post_reset_load", r);
  endtask

  task automatic test_random();
    logic [31:0] r, adr;
    int k;
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) adr = 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
      else adr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      run_xfer(k, adr, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 1), "random", r);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_load();
    test_byte_store();
    test_wait_states();
    test_addr_check();
    test_hold();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
